// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done bus of the sequential divider.
// master drives start and operands; slave returns status and results.
interface seq_divider_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clk.
// Ports: clk, rst (sync, active-high), bus (seq_divider_if.slave):
//   start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands.
module seq_divider #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  // Magnitude of most-negative fits as an unsigned WIDTH-bit value.
  assign a_mag = bus.dividend[WIDTH-1] ?
                 -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1] ?
                 -bus.divisor : bus.divisor;
  assign q_out = q_neg ? -dvd_nx : dvd_nx;
  assign r_out = r_neg ? -rem_nx : rem_nx;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_out = dvd_nx;
  assign r_out = rem_nx;
`endif

  // Stored remainder is always < divisor, so WIDTH bits suffice;
  // the shifted value needs one extra bit for the trial subtract.
  always_comb begin
    shl   = {rem, dvd[WIDTH-1]};
    trial = shl - {1'b0, dsr};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      dvd_nx = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shl[WIDTH-1:0];
      dvd_nx = {dvd[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      rem             <= '0;
      dvd             <= '0;
      dsr             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
              count    <= CW'(WIDTH);
              rem      <= '0;
              dvd      <= a_mag;
              dsr      <= b_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
              q_neg    <= bus.dividend[WIDTH-1] ^
                          bus.divisor[WIDTH-1];
              r_neg    <= bus.dividend[WIDTH-1];
`endif
            end
          end
        end
        RUN: begin
          rem   <= rem_nx;
          dvd   <= dvd_nx;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_out;
            bus.remainder   <= r_out;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
